reg_bank: RTL

Parametrised multi-register bank that succeeds the single 4-bit data register in the CPU datapath. It provides `DEPTH` registers of `WIDTH` bits, one write port that can apply an in-place operation (load, increment, decrement, clear, shift), and two combinational read ports. Registered carry and zero flags are updated by every effective write. The bank feeds the ALU operand buses and receives results and immediates from the decoder.

---
 rtl/reg_bank_pkg.sv | 24 ++
 rtl/reg_bank_alu.sv | 42 ++++
 rtl/reg_bank.sv | 70 +++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: write-op encodings shared by the register bank and the decoder.
// Holds op_t and the matching OP_* constants.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    LOAD = 3'd1,
    INC  = 3'd2,
    DEC  = 3'd3,
    CLR  = 3'd4,
    SHL  = 3'd5,
    SHR  = 3'd6,
    RSV  = 3'd7
  } op_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;

endpackage

// File: rtl/reg_bank_alu.sv
// reg_bank_alu: combinational write-op unit for reg_bank.
// In: op, r (stored value), data. Out: res, cy (carry/borrow/shift-out), vld (op writes).
module reg_bank_alu
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] res,
  output logic             cy,
  output logic             vld
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    res = r;
    cy  = 1'b0;
    vld = 1'b1;
    unique case (op)
      LOAD: res = data;
      INC:  {cy, res} = {1'b0, r} + {1'b0, ONE};
      DEC: begin
        res = r - ONE;
        cy  = (r == '0);
      end
      CLR:  res = '0;
      SHL: begin
        res = {r[WIDTH-2:0], 1'b0};
        cy  = r[WIDTH-1];
      end
      SHR: begin
        res = {1'b0, r[WIDTH-1:1]};
        cy  = r[0];
      end
      default: vld = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank, one op-write port, two comb read ports.
// In: clk, rst, op, wr_addr, data, rd_addr_a/b. Out: d_out_a/b, carry, zero.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int DEPTH  = 4,
  parameter  bit BYPASS = 1'b1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  op_t               op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  d_out_a,
  output logic [WIDTH-1:0]  d_out_b,
  output logic              carry,
  output logic              zero
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] res;
  logic             cy;
  logic             vld;
  logic             wr_ok;
  logic             we;

  assign wr_ok = 32'(wr_addr) < DEPTH;
  assign r_cur = wr_ok ? mem[wr_addr] : '0;
  // A write sampled under reset is lost, so it must not be forwarded either.
  assign we    = vld & wr_ok & ~rst;

  reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .op  (op),
    .r   (r_cur),
    .data(data),
    .res (res),
    .cy  (cy),
    .vld (vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (we) begin
      mem[wr_addr] <= res;
      carry        <= cy;
      zero         <= (res == '0);
    end
  end

  always_comb begin
    d_out_a = '0;
    if (32'(rd_addr_a) < DEPTH) d_out_a = mem[rd_addr_a];
    if (BYPASS && we && rd_addr_a == wr_addr) d_out_a = res;
  end

  always_comb begin
    d_out_b = '0;
    if (32'(rd_addr_b) < DEPTH) d_out_b = mem[rd_addr_b];
    if (BYPASS && we && rd_addr_b == wr_addr) d_out_b = res;
  end

endmodule
